// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared constants for the UART receive controller.
// State one-hot encoding, parity type codes and PRESCALE bounds.
package uart_rx_pkg;

    typedef enum logic [5:0] {
        ST_IDLE   = 6'b000001,
        ST_START  = 6'b000010,
        ST_DATA   = 6'b000100,
        ST_PARITY = 6'b001000,
        ST_STOP   = 6'b010000,
        ST_DONE   = 6'b100000
    } state_t;

    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD  = 1'b1;

    localparam int PRESCALE_MIN = 8;
    localparam int PRESCALE_MAX = 32;

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// uart_rx_ctrl_if: received-frame bundle towards the RX data consumer.
// master drives P_DATA, DATA_VALID, PAR_ERR, STP_ERR, BUSY; slave observes.
interface uart_rx_ctrl_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  DATA_VALID;
    logic                  PAR_ERR;
    logic                  STP_ERR;
    logic                  BUSY;

    modport master (
        output P_DATA, DATA_VALID, PAR_ERR, STP_ERR, BUSY
    );

    modport slave (
        input P_DATA, DATA_VALID, PAR_ERR, STP_ERR, BUSY
    );
endinterface

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: per-bit edge counter and mid-bit sampling of RX_IN.
// In: CLK, RST, run, rx_in, prescale. Out: bit_done, sampled_bit.
// UART_RX_MAJORITY_EN selects a 3-sample vote instead of one sample.
module uart_rx_sampler #(
    parameter int PRESCALE_W = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  run,
    input  logic                  rx_in,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  bit_done,
    output logic                  sampled_bit
);
    localparam logic [PRESCALE_W-1:0] ONE = PRESCALE_W'(1);

    logic [PRESCALE_W-1:0] edge_cnt;
    logic [PRESCALE_W-1:0] last_cnt;
    logic [PRESCALE_W-1:0] mid_cnt;

    assign last_cnt = prescale - ONE;
    assign mid_cnt  = prescale >> 1;
    assign bit_done = run && (edge_cnt == last_cnt);

    // Held at 0 outside a bit so every bit starts from count 0.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            edge_cnt <= '0;
        end else if (!run || bit_done) begin
            edge_cnt <= '0;
        end else begin
            edge_cnt <= edge_cnt + ONE;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    logic early;
    logic centre;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            early       <= 1'b0;
            centre      <= 1'b0;
            sampled_bit <= 1'b0;
        end else if (run) begin
            if (edge_cnt == mid_cnt - ONE) early <= rx_in;
            if (edge_cnt == mid_cnt) centre <= rx_in;
            if (edge_cnt == mid_cnt + ONE) begin
                sampled_bit <= (early & centre) |
                               (early & rx_in) |
                               (centre & rx_in);
            end
        end
    end
`else
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sampled_bit <= 1'b0;
        end else if (run && edge_cnt == mid_cnt) begin
            sampled_bit <= rx_in;
        end
    end
`endif

endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: UART receive FSM, bit counter, deserializer, checkers.
// In: CLK, RST, RX_IN, PRESCALE, PAR_EN, PAR_TYP, STOP2. Out: rx_bus.
// Optional macro UART_RX_MAJORITY_EN enables 3-sample bit voting.
module uart_rx_ctrl
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic [PRESCALE_W-1:0] PRESCALE,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  STOP2,
    uart_rx_ctrl_if.master        rx_bus
);
    localparam int BW = $clog2(DATA_WIDTH);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);
    localparam logic [BW-1:0] ONE = BW'(1);

    state_t                  state;
    logic [PRESCALE_W-1:0]   cfg_prescale;
    logic                    cfg_par_en;
    logic                    cfg_par_typ;
    logic                    cfg_stop2;
    logic [BW-1:0]           bit_cnt;
    logic [DATA_WIDTH-1:0]   shift;
    logic                    par_fail;
    logic                    stp_fail;
    logic                    run;
    logic                    bit_done;
    logic                    sampled;
    logic                    par_exp;
    logic                    stp_now;

    assign run = (state == ST_START) || (state == ST_DATA) ||
                 (state == ST_PARITY) || (state == ST_STOP);

    assign par_exp = (^shift) ^ (cfg_par_typ == PARITY_ODD);
    assign stp_now = stp_fail | ~sampled;

    assign rx_bus.BUSY = (state != ST_IDLE);

    uart_rx_sampler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_sampler (
        .CLK         (CLK),
        .RST         (RST),
        .run         (run),
        .rx_in       (RX_IN),
        .prescale    (cfg_prescale),
        .bit_done    (bit_done),
        .sampled_bit (sampled)
    );

    // Flags are set on the cycle entering DONE so they are high in DONE.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state             <= ST_IDLE;
            cfg_prescale      <= '0;
            cfg_par_en        <= 1'b0;
            cfg_par_typ       <= 1'b0;
            cfg_stop2         <= 1'b0;
            bit_cnt           <= '0;
            shift             <= '0;
            par_fail          <= 1'b0;
            stp_fail          <= 1'b0;
            rx_bus.P_DATA     <= '0;
            rx_bus.DATA_VALID <= 1'b0;
            rx_bus.PAR_ERR    <= 1'b0;
            rx_bus.STP_ERR    <= 1'b0;
        end else begin
            rx_bus.DATA_VALID <= 1'b0;
            rx_bus.PAR_ERR    <= 1'b0;
            rx_bus.STP_ERR    <= 1'b0;
            unique case (state)
                ST_IDLE, ST_DONE: begin
                    bit_cnt  <= '0;
                    par_fail <= 1'b0;
                    stp_fail <= 1'b0;
                    if (!RX_IN) begin
                        state        <= ST_START;
                        cfg_prescale <= PRESCALE;
                        cfg_par_en   <= PAR_EN;
                        cfg_par_typ  <= PAR_TYP;
                        cfg_stop2    <= STOP2;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_START: begin
                    if (bit_done) begin
                        state <= sampled ? ST_IDLE : ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (bit_done) begin
                        shift <= {sampled, shift[DATA_WIDTH-1:1]};
                        if (bit_cnt == LAST_BIT) begin
                            bit_cnt <= '0;
                            state   <= cfg_par_en ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_cnt <= bit_cnt + ONE;
                        end
                    end
                end
                ST_PARITY: begin
                    if (bit_done) begin
                        if (sampled != par_exp) par_fail <= 1'b1;
                        state <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (bit_done) begin
                        if (cfg_stop2 && bit_cnt == '0) begin
                            bit_cnt  <= ONE;
                            stp_fail <= stp_now;
                        end else begin
                            state             <= ST_DONE;
                            stp_fail          <= stp_now;
                            rx_bus.DATA_VALID <= ~par_fail & ~stp_now;
                            rx_bus.PAR_ERR    <= par_fail;
                            rx_bus.STP_ERR    <= stp_now;
                            if (!par_fail && !stp_now) begin
                                rx_bus.P_DATA <= shift;
                            end
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: randomized frames checked against a frame-level model.
// Expected events carry the DONE cycle, flags and visible P_DATA.
module tb_uart_rx_ctrl;
    import uart_rx_pkg::*;

    localparam int DW = 8;
    localparam int PW = 6;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          RX_IN = 1'b1;
    logic [PW-1:0] PRESCALE = PW'(8);
    logic          PAR_EN = 1'b0;
    logic          PAR_TYP = 1'b0;
    logic          STOP2 = 1'b0;

    uart_rx_ctrl_if #(.DATA_WIDTH(DW)) bus ();

    uart_rx_ctrl #(
        .DATA_WIDTH (DW),
        .PRESCALE_W (PW)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .RX_IN    (RX_IN),
        .PRESCALE (PRESCALE),
        .PAR_EN   (PAR_EN),
        .PAR_TYP  (PAR_TYP),
        .STOP2    (STOP2),
        .rx_bus   (bus)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        int            t;
        logic          v;
        logic          pe;
        logic          se;
        logic [DW-1:0] d;
    } ev_t;

    ev_t got_q[$];
    ev_t exp_q[$];

    always @(negedge CLK) begin
        if (bus.DATA_VALID || bus.PAR_ERR || bus.STP_ERR)
            got_q.push_back('{cyc, bus.DATA_VALID, bus.PAR_ERR,
                              bus.STP_ERR, bus.P_DATA});
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Model state: last DONE cycle, last good data, receiver lag.
    int            prev_d = -100;
    int            last_o = 0;
    logic [DW-1:0] last_good = '0;

    task automatic idle(input int g);
        repeat (g) begin
            @(negedge CLK);
            RX_IN = 1'b1;
        end
    endtask

    task automatic send_frame(input int p, input logic pe, input logic pt,
                              input logic s2, input logic [DW-1:0] d,
                              input logic bp, input logic [1:0] sv,
                              input int gb);
        logic line[$];
        int   n;
        int   line_e;
        int   eff;
        int   o;
        logic v;
        logic perr;
        logic serr;
        logic ok;
        line.push_back(1'b0);
        for (int b = 0; b < DW; b++) line.push_back(d[b]);
        if (pe) line.push_back(^d ^ pt ^ bp);
        line.push_back(sv[0]);
        if (s2) line.push_back(sv[1]);
        n = line.size();
        @(negedge CLK);
        PRESCALE = PW'(p);
        PAR_EN   = pe;
        PAR_TYP  = pt;
        STOP2    = s2;
        line_e = cyc + 1;
        eff = (line_e > prev_d + 1) ? line_e : prev_d + 1;
        o = eff - line_e;
        for (int i = 0; i < n; i++) begin
            for (int c = 0; c < p; c++) begin
                if (i != 0 || c != 0) @(negedge CLK);
                v = line[i];
                if (gb >= 0 && i == 1 + gb && c == o + 1 + p / 2) v = ~v;
                RX_IN = v;
                if (i == 2 && c == 0) begin
                    PRESCALE = PW'($urandom_range(0, 63));
                    PAR_EN   = 1'($urandom_range(0, 1));
                    PAR_TYP  = 1'($urandom_range(0, 1));
                    STOP2    = 1'($urandom_range(0, 1));
                end
                if (i == 3 && c == 0) check("busy_mid", bus.BUSY, 1);
            end
        end
        perr = pe && bp;
        serr = !sv[0] || (s2 && !sv[1]);
        ok = !perr && !serr;
        if (ok) last_good = d;
        exp_q.push_back('{eff + n * p, ok, perr, serr, last_good});
        prev_d = eff + n * p;
        last_o = o;
    endtask

    task automatic short_low(input int p);
        int e;
        @(negedge CLK);
        PRESCALE = PW'(p);
        e = cyc + 1;
        RX_IN = 1'b0;
        repeat (2) begin
            @(negedge CLK);
            RX_IN = 1'b0;
        end
        @(negedge CLK);
        RX_IN = 1'b1;
        while (cyc < e + p - 1) @(negedge CLK);
        check("glitch_busy_hi", bus.BUSY, 1);
        @(negedge CLK);
        check("glitch_busy_lo", bus.BUSY, 0);
        prev_d = e + p;
        last_o = 0;
    endtask

    initial begin
        repeat (3) @(negedge CLK);
        check("rst_pdata", bus.P_DATA, 0);
        check("rst_valid", bus.DATA_VALID, 0);
        check("rst_perr", bus.PAR_ERR, 0);
        check("rst_serr", bus.STP_ERR, 0);
        check("rst_busy", bus.BUSY, 0);
        RST = 1'b1;
        idle(5);

        send_frame(8, 0, 0, 0, 8'hA5, 0, 2'b11, -1);
        idle(4);
        send_frame(16, 1, PARITY_EVEN, 0, 8'h3C, 0, 2'b11, -1);
        idle(4);
        send_frame(16, 1, PARITY_EVEN, 0, 8'h3C, 1, 2'b11, -1);
        idle(4);
        send_frame(8, 0, 0, 1, 8'h5A, 0, 2'b01, -1);
        idle(6);
        short_low(8);
        idle(6);
        send_frame(8, 0, 0, 0, 8'h11, 0, 2'b11, -1);
        send_frame(8, 0, 0, 0, 8'h22, 0, 2'b11, -1);
        idle(4);
`ifdef UART_RX_MAJORITY_EN
        send_frame(8, 0, 0, 0, 8'hC3, 0, 2'b11, 3);
        idle(4);
`endif

        for (int k = 0; k < 40; k++) begin
            int            p;
            int            g;
            int            gb;
            logic          pe;
            logic          pt;
            logic          s2;
            logic          bp;
            logic [1:0]    sv;
            logic [DW-1:0] d;
            p  = 2 * $urandom_range(PRESCALE_MIN / 2, PRESCALE_MAX / 2);
            pe = 1'($urandom_range(0, 1));
            pt = 1'($urandom_range(0, 1));
            s2 = 1'($urandom_range(0, 1));
            bp = ($urandom_range(0, 3) == 0);
            d  = DW'($urandom);
            sv = 2'b11;
            if ($urandom_range(0, 5) == 0) sv[0] = 1'b0;
            if ($urandom_range(0, 5) == 0) sv[1] = 1'b0;
            gb = -1;
`ifdef UART_RX_MAJORITY_EN
            if ($urandom_range(0, 1) == 1) gb = $urandom_range(0, DW - 1);
`endif
            if (last_o == 0 && $urandom_range(0, 2) == 0) g = 0;
            else g = $urandom_range(1, 6);
            idle(g);
            send_frame(p, pe, pt, s2, d, bp, sv, gb);
        end
        idle(10);

        // Abort a frame with reset part way through the data bits.
        @(negedge CLK);
        PRESCALE = PW'(8);
        RX_IN = 1'b0;
        repeat (7) begin
            @(negedge CLK);
            RX_IN = 1'b0;
        end
        repeat (32) begin
            @(negedge CLK);
            RX_IN = 1'($urandom_range(0, 1));
        end
        check("busy_pre_rst", bus.BUSY, 1);
        #2 RST = 1'b0;
        #1;
        check("arst_pdata", bus.P_DATA, 0);
        check("arst_valid", bus.DATA_VALID, 0);
        check("arst_perr", bus.PAR_ERR, 0);
        check("arst_serr", bus.STP_ERR, 0);
        check("arst_busy", bus.BUSY, 0);
        idle(4);
        RST = 1'b1;
        prev_d = -100;
        last_o = 0;
        last_good = '0;
        idle(5);
        check("post_rst_busy", bus.BUSY, 0);
        send_frame(8, 1, PARITY_ODD, 0, 8'h96, 0, 2'b11, -1);
        idle(20);

        check("n_events", got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            check($sformatf("ev%0d_t", i), got_q[i].t, exp_q[i].t);
            check($sformatf("ev%0d_valid", i), got_q[i].v, exp_q[i].v);
            check($sformatf("ev%0d_perr", i), got_q[i].pe, exp_q[i].pe);
            check($sformatf("ev%0d_serr", i), got_q[i].se, exp_q[i].se);
            check($sformatf("ev%0d_data", i), got_q[i].d, exp_q[i].d);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
Parametrised UART receive controller for the final-system RX path. It integrates the frame FSM, the oversampling edge counter, the bit counter, the deserializer and the parity/stop checkers into one block. It adds runtime-selectable parity type and 1 or 2 stop bits, back-to-back frame reception, and one-cycle error flags. It sits between the RX pin (already in the CLK domain) and the RX data consumer.

Parameters:
DATA_WIDTH, 8, data bits per frame; legal range 5..9.
PRESCALE_W, 6, width of the PRESCALE input and of the edge counter.

Ports:
CLK  in  1  oversampling clock; one edge-count tick per cycle
RST  in  1  asynchronous, active-low reset
RX_IN  in  1  serial line; idle high
PRESCALE  in  PRESCALE_W  oversampling ratio; legal values are even numbers 8..32
PAR_EN  in  1  1 = parity bit present
PAR_TYP  in  1  0 = even parity, 1 = odd parity
STOP2  in  1  0 = one stop bit, 1 = two stop bits
P_DATA  out  DATA_WIDTH  last good frame, LSB received first
DATA_VALID  out  1  one-cycle pulse when P_DATA updates
PAR_ERR  out  1  one-cycle pulse on parity mismatch
STP_ERR  out  1  one-cycle pulse on a stop bit sampled as 0
BUSY  out  1  high in every state except IDLE

Behaviour:
- Reset: state IDLE; all counters 0; P_DATA = 0; DATA_VALID, PAR_ERR, STP_ERR and BUSY = 0. Reset asserted mid-frame aborts the frame with no flags.
- Config capture: PRESCALE, PAR_EN, PAR_TYP and STOP2 are latched on the IDLE->START transition. Changes mid-frame are ignored until the next frame.
- States: IDLE, START, DATA, PARITY, STOP, DONE. One-hot encoding is used.
- Edge counter: 0 in the first cycle of each bit and counts to PRESCALE-1. At PRESCALE-1 the bit ends, the counter wraps to 0 and the bit counter increments.
- Bit sample: majority vote of RX_IN at edge counts PRESCALE/2-1, PRESCALE/2 and PRESCALE/2+1. The vote is registered at count PRESCALE/2+1.
- IDLE: if RX_IN = 0, go to START with the edge counter at 0 in the first START cycle.
- START: at end of bit, go to DATA if the sampled bit is 0. If the sampled bit is 1 (glitch), go to IDLE with no flags.
- DATA: shift in DATA_WIDTH bits, LSB first, into an internal shift register. After the last bit, go to PARITY if PAR_EN = 1, else go to STOP.
- PARITY: at end of bit, compare against even or odd parity of the shifted data. On mismatch, latch an internal par_fail. Always continue to STOP.
- STOP: one or two bits per STOP2. Any stop bit sampled as 0 latches stp_fail. After the last stop bit, go to DONE.
- DONE (exactly one cycle):
  - DATA_VALID = 1 and P_DATA <= shift register only if par_fail = 0 and stp_fail = 0.
  - PAR_ERR = par_fail and STP_ERR = stp_fail; both may pulse together.
  - P_DATA is unchanged on error.
  - Next state is START if RX_IN = 0 (back-to-back frame, counters cleared), else IDLE.
- Latency: with the first START cycle at t = 0, DONE occurs at t = PRESCALE*(1+DATA_WIDTH+PAR_EN+1+STOP2).
- Outputs: registered in DONE and low in every other cycle. BUSY is decoded from state.

Optional Feature:
- Macro: UART_RX_MAJORITY_EN.
- Defined: 3-sample majority vote as above.
- Undefined: a single sample at edge count PRESCALE/2, registered the same cycle. The vote logic and the two extra sample flops are removed. Frame timing and latency are unchanged.

Decomposition:
- Package uart_rx_pkg holds the state encoding constants, PARITY_EVEN = 0 / PARITY_ODD = 1, and the legal PRESCALE bounds (8, 32).
- Sub-module uart_rx_sampler holds the edge counter, the sample-point decode and the majority vote. Its outputs are bit_done and sampled_bit.
- The FSM, bit counter, shift register and checkers stay in the top level.

Test Plan:
- PRESCALE=8, PAR_EN=0, STOP2=0, send 0xA5 -> DATA_VALID pulse at t=80, P_DATA=0xA5, no error flags.
- PRESCALE=16, PAR_EN=1, PAR_TYP=0, send 0x3C with parity 0 -> valid. Repeat with parity bit 1 -> PAR_ERR pulse at t=176, no DATA_VALID, P_DATA stays 0x3C.
- PRESCALE=8, STOP2=1, second stop bit 0 -> STP_ERR pulse at t=88, no DATA_VALID. Then RX_IN high -> IDLE.
- RX_IN low for 3 cycles only, PRESCALE=8 -> START returns to IDLE at t=8, BUSY drops, no pulses.
- Two frames 0x11, 0x22 with no idle gap -> two DATA_VALID pulses exactly 80 cycles apart. PRESCALE change during frame 1 takes effect only at frame 2.
- With UART_RX_MAJORITY_EN, a one-cycle RX_IN inversion at edge count PRESCALE/2 inside a data bit -> the bit is received correctly. RST low at mid-frame -> all outputs 0, state IDLE.
